// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions.
//   resp_t           : AXI response codes carried on bresp/rresp and reported on rsp_resp.
//   axil_mst_state_t : state encoding of the axil_master transaction FSM.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Fixed encodings keep the state values stable for anything that decodes them externally.
  typedef enum logic [2:0] {
    StIdle = 3'd0,  // waiting for a command
    StWr   = 3'd1,  // AW and W in flight
    StWb   = 3'd2,  // waiting for B
    StRa   = 3'd3,  // AR in flight
    StRd   = 3'd4,  // waiting for R
    StRsp  = 3'd5   // presenting the response
  } axil_mst_state_t;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator. Turns a single-beat command/response handshake into one AXI-Lite
// read or write transaction at a time. Every output is driven straight from a register.
//
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb            command payload (wdata/wstrb ignored for reads)
//   rsp_valid/rsp_ready             response handshake
//   rsp_write, rsp_rdata, rsp_resp  response payload (rdata is 0 for writes and timeouts)
//   aw*, w*, b*, ar*, r*            AXI4-Lite initiator channels
//
// Parameters:
//   ADDR_WIDTH  byte-address width
//   DATA_WIDTH  data width, a multiple of 8
//   TIMEOUT     cycles allowed per AXI handshake before giving up with SLVERR; 0 disables
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI4-Lite write response
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TIMER_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  axil_mst_state_t state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  resp_t                 rsp_resp_q, rsp_resp_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cmd_hs, rsp_hs;
  logic timed_out;
  logic abort;

  assign aw_hs  = awvalid_q & awready;
  assign w_hs   = wvalid_q & wready;
  assign b_hs   = bvalid & bready_q;
  assign ar_hs  = arvalid_q & arready;
  assign r_hs   = rvalid & rready_q;
  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  // The timer is reloaded to 1 on entry to a waiting state, so it equals the number of
  // cycles spent waiting and expiry fires on the TIMEOUT-th cycle.
  assign timed_out = (TIMEOUT != 0) && (timer_q == TIMER_MAX);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    write_d     = write_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    abort       = 1'b0;

    timer_d = timer_q;
    if ((TIMEOUT != 0) && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + TIMER_ONE;
    end

    unique case (state_q)
      StIdle: begin
        // Beats left over from an abandoned transaction are taken with a one-cycle ready
        // pulse; the responder holds valid until then, so the pulse always completes.
        bready_d = bvalid & ~bready_q;
        rready_d = rvalid & ~rready_q;
        if (cmd_hs) begin
          cmd_ready_d = 1'b0;
          write_d     = cmd_write;
          awaddr_d    = cmd_addr;
          araddr_d    = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          timer_d     = TIMER_ONE;
          if (cmd_write) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRa;
            arvalid_d = 1'b1;
          end
        end
      end

      StWr: begin
        // Ends any drain pulse that was started on the command cycle.
        bready_d = 1'b0;
        rready_d = 1'b0;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
          timer_d   = TIMER_ONE;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
          timer_d  = TIMER_ONE;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = StWb;
          bready_d = 1'b1;
          timer_d  = TIMER_ONE;
        end else if (timed_out && !aw_hs && !w_hs) begin
          abort = 1'b1;
        end
      end

      StWb: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = resp_t'(bresp);
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      StRa: begin
        bready_d = 1'b0;
        rready_d = 1'b0;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRd;
          timer_d   = TIMER_ONE;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      StRd: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = resp_t'(rresp);
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      StRsp: begin
        // cmd_ready rises only after the response handshake, so a command can never be
        // taken in the same cycle.
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // A stuck responder: give up on the channel and report SLVERR.
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      state_d     = StRsp;
      rsp_valid_d = 1'b1;
      rsp_write_d = write_q;
      rsp_rdata_d = '0;
      rsp_resp_d  = SLVERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      write_q     <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timer_q     <= timer_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master with an in-bench AXI-Lite memory responder whose
// ready/valid timing is steered per test.
module tb_axil_master;
  import axil_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready = 1'b1, wvalid, wready = 1'b1;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic          bvalid = 1'b0, bready, arvalid, arready = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rvalid = 1'b0, rready;

  axil_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;

  // responder state
  logic [7:0]  mem [256];
  int          aw_block = 0, ar_block = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          aw_have = 0, w_have = 0, b_pend = 0, r_pend = 0, allow_drop = 0;
  int          b_wait = 0, r_wait = 0;
  logic [7:0]  aw_a = '0, ar_a = '0;
  logic [31:0] w_d = '0;
  logic [3:0]  w_s = '0;
  int          aw_edge = 0, w_edge = 0, ar_edge = 0, bready_rise = 0;
  int          rsp_count = 0, ar_high_cnt = 0, rready_cnt = 0, rspv_cnt = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [7:0] a);
    int b;
    b = {24'd0, a[7:2], 2'b00};
    return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
  endfunction

  // One clock: note handshakes before the edge, then monitor and update the responder.
  task automatic tick();
    bit aw_h, w_h, b_h, ar_h, r_h, rsp_h, p_awv, p_wv, p_arv, p_rr, p_br;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    int          base;
    aw_h  = awvalid && awready;
    w_h   = wvalid && wready;
    b_h   = bvalid && bready;
    ar_h  = arvalid && arready;
    r_h   = rvalid && rready;
    rsp_h = rsp_valid && rsp_ready;
    p_awv = awvalid; p_wv = wvalid; p_arv = arvalid; p_rr = rready; p_br = bready;
    p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
    @(posedge clk);
    cyc++;
    #1;
    if (!allow_drop) begin
      if (p_awv && !aw_h && (!awvalid || awaddr !== p_awaddr)) viol++;
      if (p_wv && !w_h && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
      if (p_arv && !ar_h && (!arvalid || araddr !== p_araddr)) viol++;
      if (p_rr && !r_h && !rready) viol++;
      if (p_br && !b_h && !bready) viol++;
    end
    if (aw_h && awvalid) viol++;
    if (w_h && wvalid) viol++;
    if (ar_h && arvalid) viol++;
    if (rsp_h) rsp_count++;
    if (bready && !p_br) bready_rise = cyc;
    if (arvalid) ar_high_cnt++;
    if (rready) rready_cnt++;
    if (rsp_valid) rspv_cnt++;
    if (b_h) bvalid = 1'b0;
    if (r_h) rvalid = 1'b0;
    if (aw_h) begin aw_have = 1; aw_a = p_awaddr; aw_edge = cyc; end
    if (w_h) begin w_have = 1; w_d = p_wdata; w_s = p_wstrb; w_edge = cyc; end
    if (ar_h) begin r_pend = 1; ar_a = p_araddr; r_wait = r_delay; ar_edge = cyc; end
    if (aw_have && w_have && !b_pend && !bvalid) begin
      base = {24'd0, aw_a[7:2], 2'b00};
      for (int i = 0; i < 4; i++) if (w_s[i]) mem[base + i] = w_d[8*i +: 8];
      aw_have = 0; w_have = 0; b_pend = 1; b_wait = b_delay;
    end
    if (b_pend) begin
      if (b_wait == 0) begin bvalid = 1'b1; bresp = bresp_cfg; b_pend = 0; end
      else b_wait--;
    end
    if (r_pend) begin
      if (r_wait == 0) begin rvalid = 1'b1; rdata = mem_rd(ar_a); rresp = 2'b00; r_pend = 0; end
      else r_wait--;
    end
    if (aw_block > 0) aw_block--;
    if (ar_block > 0) ar_block--;
    awready = (aw_block == 0);
    arready = (ar_block == 0);
  endtask

  // Issue one command, wait for the response, hold rsp_ready low for rsp_hold cycles.
  // lat = first clock edge (counted from the command handshake edge) with rsp_valid high.
  task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] d,
                        input logic [3:0] strb, input int rsp_hold,
                        output logic [31:0] r_data, output logic [1:0] r_resp,
                        output logic r_wr, output int lat, output int t0);
    bit hs;
    int n;
    r_data = 'x; r_resp = 'x; r_wr = 1'bx; lat = -1; t0 = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = strb;
    n = 0;
    do begin
      hs = cmd_ready;
      tick();
      n++;
    end while (!hs && n < 20);
    cmd_valid = 1'b0;
    if (!hs) begin
      check("cmd_handshake_bound", 0, 1);
      return;
    end
    t0 = cyc;
    n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    if (!rsp_valid) begin
      check("rsp_valid_bound", 0, 1);
      return;
    end
    lat = cyc - t0 + 1;
    r_data = rsp_rdata; r_resp = rsp_resp; r_wr = rsp_write;
    for (int i = 0; i < rsp_hold; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== r_data || rsp_resp !== r_resp || cmd_ready) viol++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rw;
    int          lat, t0, cnt_before, n;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 3};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 3};
    vecs[2] = '{1'b1, 8'h14, 32'h12345678, 4'hF, 32'h0,        2'b00, 3};
    vecs[3] = '{1'b1, 8'h14, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00, 3};
    vecs[4] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'h12BB56DD, 2'b00, 3};
    vecs[5] = '{1'b1, 8'h18, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 3};
    vecs[6] = '{1'b0, 8'h18, 32'h0,        4'h0, 32'h00000000, 2'b00, 3};
    vecs[7] = '{1'b1, 8'h23, 32'h77000000, 4'h8, 32'h0,        2'b00, 3};
    vecs[8] = '{1'b0, 8'h21, 32'h0,        4'h0, 32'h77000000, 2'b00, 3};
    vecs[9] = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'h00000000, 2'b00, 3};

    // reset state
    #1 rst = 1'b1;
    #12;
    check("reset_outputs",
          {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write,
           rsp_rdata, rsp_resp},
          {1'b1, 7'b0, 32'h0, 2'b00});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // table of back-to-back transactions against an always-ready responder
    for (int v = 0; v < 10; v++) begin
      do_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 0, rd, rs, rw, lat, t0);
      check($sformatf("v%0d_rsp_write", v), rw, vecs[v].wr);
      check($sformatf("v%0d_rsp_resp", v), rs, vecs[v].exp_resp);
      check($sformatf("v%0d_rsp_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      if (vecs[v].wr) begin
        check($sformatf("v%0d_awaddr", v), aw_a, vecs[v].addr);
        check($sformatf("v%0d_wstrb", v), w_s, vecs[v].strb);
        check($sformatf("v%0d_aw_w_edge", v), {aw_edge - t0, w_edge - t0}, {32'd1, 32'd1});
      end else begin
        check($sformatf("v%0d_araddr", v), ar_a, vecs[v].addr);
        check($sformatf("v%0d_ar_edge", v), ar_edge - t0, 1);
      end
    end
    check("table_protocol", viol, 0);
    check("table_rsp_count", rsp_count, 10);

    // awready low for 5 cycles: W completes first, AW waits, B only after AW
    viol = 0; cnt_before = rsp_count;
    aw_block = 5; awready = 1'b0;
    do_txn(1'b1, 8'h30, 32'h0BADCAFE, 4'hF, 0, rd, rs, rw, lat, t0);
    check("awstall_w_edge", w_edge - t0, 1);
    check("awstall_aw_edge", aw_edge - t0, 5);
    check("awstall_bready_rise", bready_rise - t0, 5);
    check("awstall_resp", {rw, rs}, {1'b1, 2'b00});
    check("awstall_latency", lat, 7);
    check("awstall_protocol", viol, 0);
    check("awstall_single_rsp", rsp_count - cnt_before, 1);

    // read with rvalid late by 3 cycles and rsp_ready held low 4 cycles
    do_txn(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 0, rd, rs, rw, lat, t0);
    viol = 0;
    r_delay = 3;
    do_txn(1'b0, 8'h20, 32'h0, 4'h0, 4, rd, rs, rw, lat, t0);
    r_delay = 0;
    check("rdelay_rdata", rd, 32'hCAFEF00D);
    check("rdelay_resp", {rw, rs}, {1'b0, 2'b00});
    check("rdelay_latency", lat, 6);
    check("rdelay_hold_protocol", viol, 0);
    check("rdelay_cmd_ready_after", cmd_ready, 1'b1);

    // error response passes through
    bresp_cfg = 2'b11;
    do_txn(1'b1, 8'h34, 32'h5A5A5A5A, 4'hF, 0, rd, rs, rw, lat, t0);
    bresp_cfg = 2'b00;
    check("decerr_resp", {rw, rs, rd}, {1'b1, 2'b11, 32'h0});

    // stuck arready: timeout after 8 cycles, then a stray R beat is absorbed silently
    allow_drop = 1; ar_high_cnt = 0;
    ar_block = 100000; arready = 1'b0;
    do_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, rd, rs, rw, lat, t0);
    check("timeout_arvalid_cycles", ar_high_cnt, 8);
    check("timeout_latency", lat, 9);
    check("timeout_resp", {rw, rs, rd}, {1'b0, 2'b10, 32'h0});
    ar_block = 0; arready = 1'b1;
    allow_drop = 0; viol = 0;
    cnt_before = rsp_count; rready_cnt = 0; rspv_cnt = 0;
    rvalid = 1'b1; rdata = 32'h55555555; rresp = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    check("late_r_absorbed", rvalid, 1'b0);
    check("late_r_rready_pulse", rready_cnt, 1);
    check("late_r_no_rsp", {rspv_cnt, rsp_count - cnt_before}, 64'd0);
    check("late_r_protocol", viol, 0);

    // reset while waiting for B
    b_delay = 50;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 32'h11111111;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 10) begin tick(); n++; end
    check("wb_reached", bready, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs",
          {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write,
           rsp_rdata, rsp_resp},
          {1'b1, 7'b0, 32'h0, 2'b00});
    b_delay = 0; b_pend = 0; bvalid = 1'b0; aw_have = 0; w_have = 0; r_pend = 0;
    #3 rst = 1'b0;
    cnt_before = rsp_count;
    tick();
    check("postreset_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    do_txn(1'b1, 8'h44, 32'h600DF00D, 4'hF, 0, rd, rs, rw, lat, t0);
    check("postreset_write", {rw, rs, lat}, {1'b1, 2'b00, 32'd3});
    do_txn(1'b0, 8'h44, 32'h0, 4'h0, 0, rd, rs, rw, lat, t0);
    check("postreset_readback", {rw, rs, rd}, {1'b0, 2'b00, 32'h600DF00D});
    check("postreset_rsp_count", rsp_count - cnt_before, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
